// File: rtl/axi4lite_slave_regbank.sv
// AXI4-Lite responder exposing a bank of read/write registers.
// Independent write (AW/W/B) and read (AR/R) FSMs, one transaction each in flight.
module axi4lite_slave_regbank #(
    parameter int G_DATA_WIDTH = 32,
    parameter int G_ADDR_WIDTH = 8,
    parameter int G_NB_REG     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [G_ADDR_WIDTH-1:0]          awaddr,
    input  logic                             awvalid,
    output logic                             awready,
    input  logic [G_DATA_WIDTH-1:0]          wdata,
    input  logic [G_DATA_WIDTH/8-1:0]        wstrb,
    input  logic                             wvalid,
    output logic                             wready,
    output logic [1:0]                       bresp,
    output logic                             bvalid,
    input  logic                             bready,
    input  logic [G_ADDR_WIDTH-1:0]          araddr,
    input  logic                             arvalid,
    output logic                             arready,
    output logic [G_DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                       rresp,
    output logic                             rvalid,
    input  logic                             rready,
    output logic [G_NB_REG*G_DATA_WIDTH-1:0] o_regs,
    output logic [G_NB_REG-1:0]              o_wr_pulse
);

    localparam int NB  = G_DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e                w_state_q, w_state_d;
    r_state_e                r_state_q, r_state_d;
    logic                    en_q;
    logic [G_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [G_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]           wstrb_q, wstrb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [G_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [G_DATA_WIDTH-1:0] regs_q [G_NB_REG];
    logic [G_DATA_WIDTH-1:0] regs_d [G_NB_REG];
    logic [G_NB_REG-1:0]     wr_pulse_q, wr_pulse_d;

    logic                    aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
    logic [G_ADDR_WIDTH-1:0] c_addr, w_idx, r_idx;
    logic [G_DATA_WIDTH-1:0] c_data;
    logic [NB-1:0]           c_strb;

    // en_q keeps the readies low until the first edge after reset release
    assign awready = en_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_DATA);
    assign wready  = en_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_ADDR);
    assign arready = en_q && (r_state_q == R_IDLE);
    assign bvalid  = (w_state_q == W_RESP);
    assign rvalid  = (r_state_q == R_RESP);
    assign bresp   = bresp_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign o_wr_pulse = wr_pulse_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    assign w_idx = c_addr >> LSB;
    assign w_ok  = (w_idx < G_ADDR_WIDTH'(G_NB_REG));
    assign r_idx = araddr >> LSB;
    assign r_ok  = (r_idx < G_ADDR_WIDTH'(G_NB_REG));

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        commit    = 1'b0;
        c_addr    = awaddr;
        c_data    = wdata;
        c_strb    = wstrb;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d  = awaddr;
                    w_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                c_addr = awaddr_q;
                if (w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                c_data = wdata_q;
                c_strb = wstrb_q;
                if (aw_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (commit) begin
            bresp_d = w_ok ? 2'b00 : 2'b10;
            for (int k = 0; k < G_NB_REG; k++) begin
                if (w_ok && w_idx == G_ADDR_WIDTH'(k)) begin
                    wr_pulse_d[k] = |c_strb;
                    for (int b = 0; b < NB; b++) begin
                        if (c_strb[b]) regs_d[k][8*b +: 8] = c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read samples regs_q, so a same-edge write is not yet visible
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_RESP;
                    rresp_d   = r_ok ? 2'b00 : 2'b10;
                    rdata_d   = '0;
                    for (int k = 0; k < G_NB_REG; k++) begin
                        if (r_ok && r_idx == G_ADDR_WIDTH'(k)) rdata_d = regs_q[k];
                    end
                end
            end
            R_RESP: begin
                if (rready) r_state_d = R_IDLE;
            end
        endcase
    end

    always_comb begin
        o_regs = '0;
        for (int k = 0; k < G_NB_REG; k++) begin
            o_regs[k*G_DATA_WIDTH +: G_DATA_WIDTH] = regs_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            en_q       <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            regs_q     <= '{default: '0};
            wr_pulse_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            en_q       <= 1'b1;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regbank.sv
// Scenario bench for axi4lite_slave_regbank (32-bit data, 16 registers).
// Expected responses are queued at stimulus time and compared on DUT output.
module tb_axi4lite_slave_regbank;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   awaddr, araddr;
    logic         awvalid, wvalid, arvalid, bready, rready;
    logic         awready, wready, arready, bvalid, rvalid;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [511:0] o_regs;
    logic [15:0]  o_wr_pulse;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [15:0] pulse;
    } bexp_t;
    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    bexp_t b_q[$];
    rexp_t r_q[$];
    logic [31:0] mreg [16];

    axi4lite_slave_regbank #(
        .G_DATA_WIDTH(32), .G_ADDR_WIDTH(8), .G_NB_REG(16)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .o_regs(o_regs), .o_wr_pulse(o_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [511:0] flat_model();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = mreg[k];
        return f;
    endfunction

    function automatic void model_write(logic [7:0] a, logic [31:0] d, logic [3:0] s);
        bexp_t e;
        int idx;
        idx = int'(a >> 2);
        e.resp  = (idx < 16) ? 2'b00 : 2'b10;
        e.pulse = '0;
        if (idx < 16) begin
            mreg[idx] = merge(mreg[idx], d, s);
            e.pulse[idx] = |s;
        end
        b_q.push_back(e);
    endfunction

    function automatic void model_read(logic [7:0] a);
        rexp_t e;
        int idx;
        idx = int'(a >> 2);
        e.resp = (idx < 16) ? 2'b00 : 2'b10;
        e.data = (idx < 16) ? mreg[idx] : 32'h0;
        r_q.push_back(e);
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [15:0] pulse, output int lat);
        bit aw_done, w_done, a_hs, d_hs;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            a_hs = awvalid && awready;
            d_hs = wvalid && wready;
            tick();
            n++;
            if (a_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (d_hs) begin wvalid = 1'b0; w_done = 1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin tick(); lat++; end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL write_timeout: bvalid=%b required 1", bvalid);
        end
        resp = bresp; pulse = o_wr_pulse;
        tick();
    endtask

    task automatic do_read(input logic [7:0] a, output logic [1:0] resp,
                           output logic [31:0] data, output int lat);
        int n;
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin tick(); lat++; end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL read_timeout: rvalid=%b required 1", rvalid);
        end
        resp = rresp; data = rdata;
        tick();
    endtask

    task automatic test_reset();
        logic [1:0] rs; logic [31:0] rd; int lat; rexp_t e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, o_regs, o_wr_pulse} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b%b%b bv=%b rv=%b regs_nz=%b required all 0",
                         awready, wready, arready, bvalid, rvalid, |o_regs);
            end
        end
        rst = 1'b0;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 000", {awready, wready, arready});
        end
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_edge: got %b required 111", {awready, wready, arready});
        end
        model_read(8'h08);
        do_read(8'h08, rs, rd, lat);
        e = r_q.pop_front();
        checks++;
        if (rs !== e.resp || rd !== e.data) begin
            errors++;
            $display("FAIL reset_read: got %b/%h required %b/%h", rs, rd, e.resp, e.data);
        end
    endtask

    task automatic test_simul_write();
        logic [1:0] rs; logic [15:0] pl; logic [31:0] rd; int lat; bexp_t b; rexp_t r;
        model_write(8'h04, 32'hDEADBEEF, 4'hF);
        do_write(8'h04, 32'hDEADBEEF, 4'hF, rs, pl, lat);
        b = b_q.pop_front();
        checks++;
        if (rs !== b.resp || lat != 0) begin
            errors++;
            $display("FAIL simul_bresp: got %b lat=%0d required %b lat=0", rs, lat, b.resp);
        end
        checks++;
        if (pl !== b.pulse) begin
            errors++;
            $display("FAIL simul_pulse: got %h required %h", pl, b.pulse);
        end
        checks++;
        if (o_wr_pulse !== 16'h0) begin
            errors++;
            $display("FAIL simul_pulse_len: got %h required 0000", o_wr_pulse);
        end
        checks++;
        if (o_regs[63:32] !== 32'hDEADBEEF || o_regs !== flat_model()) begin
            errors++;
            $display("FAIL simul_regs: got %h required %h", o_regs[63:32], 32'hDEADBEEF);
        end
        model_read(8'h04);
        do_read(8'h04, rs, rd, lat);
        r = r_q.pop_front();
        checks++;
        if (rs !== r.resp || rd !== r.data || lat != 0) begin
            errors++;
            $display("FAIL simul_read: got %b/%h lat=%0d required %b/%h lat=0",
                     rs, rd, lat, r.resp, r.data);
        end
    endtask

    task automatic test_split(input bit w_first);
        logic [1:0] rs; logic [15:0] pl; int lat; bexp_t b;
        model_write(8'h04, 32'hDEADBEEF, 4'hF);
        do_write(8'h04, 32'hDEADBEEF, 4'hF, rs, pl, lat);
        b = b_q.pop_front();
        checks++;
        if (rs !== b.resp || mreg[1] !== o_regs[63:32]) begin
            errors++;
            $display("FAIL split_restore: got %b/%h required %b/%h", rs, o_regs[63:32], b.resp, mreg[1]);
        end
        model_write(8'h04, 32'h11223344, 4'h5);
        awaddr = 8'h04; wdata = 32'h11223344; wstrb = 4'h5;
        if (w_first) wvalid = 1'b1; else awvalid = 1'b1;
        tick();
        wvalid = 1'b0; awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({awready, wready} !== (w_first ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL split_ready_%0d: got aw=%b w=%b required %b", i, awready, wready,
                         w_first ? 2'b10 : 2'b01);
            end
            if (i < 2) tick();
        end
        if (w_first) awvalid = 1'b1; else wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        b = b_q.pop_front();
        checks++;
        if (bvalid !== 1'b1 || bresp !== b.resp || o_wr_pulse !== b.pulse) begin
            errors++;
            $display("FAIL split_resp: got bv=%b %b pulse=%h required 1 %b pulse=%h",
                     bvalid, bresp, o_wr_pulse, b.resp, b.pulse);
        end
        tick();
        checks++;
        if (o_regs[63:32] !== mreg[1]) begin
            errors++;
            $display("FAIL split_value: got %h required %h", o_regs[63:32], mreg[1]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] rs; logic [15:0] pl; logic [31:0] rd; int lat; bexp_t b; rexp_t r;
        model_write(8'h40, 32'h12345678, 4'hF);
        do_write(8'h40, 32'h12345678, 4'hF, rs, pl, lat);
        b = b_q.pop_front();
        checks++;
        if (rs !== b.resp || pl !== b.pulse) begin
            errors++;
            $display("FAIL oor_write: got %b pulse=%h required %b pulse=%h", rs, pl, b.resp, b.pulse);
        end
        checks++;
        if (o_regs !== flat_model()) begin
            errors++;
            $display("FAIL oor_regs: got reg0=%h reg1=%h required %h %h",
                     o_regs[31:0], o_regs[63:32], mreg[0], mreg[1]);
        end
        model_read(8'h7C);
        do_read(8'h7C, rs, rd, lat);
        r = r_q.pop_front();
        checks++;
        if (rs !== r.resp || rd !== r.data) begin
            errors++;
            $display("FAIL oor_read: got %b/%h required %b/%h", rs, rd, r.resp, r.data);
        end
    endtask

    task automatic test_backpressure();
        bexp_t b; rexp_t r;
        bready = 1'b0; rready = 1'b0;
        model_read(8'h04);
        model_write(8'h08, 32'hCAFEF00D, 4'hF);
        awaddr = 8'h08; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 8'h04;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        b = b_q.pop_front();
        r = r_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bvalid, rvalid} !== 2'b11 || bresp !== b.resp || rresp !== r.resp ||
                rdata !== r.data || {awready, wready, arready} !== 3'b000) begin
                errors++;
                $display("FAIL stall_%0d: bv=%b rv=%b %b %b %h rdy=%b required 1 1 %b %b %h 000",
                         i, bvalid, rvalid, bresp, rresp, rdata, {awready, wready, arready},
                         b.resp, r.resp, r.data);
            end
            tick();
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        checks++;
        if ({bvalid, rvalid} !== 2'b00 || {awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL stall_release: bv=%b rv=%b rdy=%b required 0 0 111",
                     bvalid, rvalid, {awready, wready, arready});
        end
        checks++;
        if (o_regs !== flat_model()) begin
            errors++;
            $display("FAIL stall_regs: got reg2=%h required %h", o_regs[95:64], mreg[2]);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] rs; logic [31:0] rd; int lat; bexp_t b; rexp_t r;
        model_read(8'h00);
        model_write(8'h00, 32'hA5A5A5A5, 4'hF);
        awaddr = 8'h00; wdata = 32'hA5A5A5A5; wstrb = 4'hF; araddr = 8'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        b = b_q.pop_front();
        r = r_q.pop_front();
        checks++;
        if (rvalid !== 1'b1 || rdata !== r.data || bvalid !== 1'b1 || bresp !== b.resp) begin
            errors++;
            $display("FAIL conc_old: rv=%b rdata=%h bv=%b required 1 %h 1", rvalid, rdata, bvalid, r.data);
        end
        tick();
        model_read(8'h00);
        do_read(8'h00, rs, rd, lat);
        r = r_q.pop_front();
        checks++;
        if (rs !== r.resp || rd !== r.data) begin
            errors++;
            $display("FAIL conc_new: got %b/%h required %b/%h", rs, rd, r.resp, r.data);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] rs; logic [31:0] rd; int lat; rexp_t r;
        awaddr = 8'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if ({awready, wready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_have_addr: got %b required 01", {awready, wready});
        end
        rst = 1'b1;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        for (int k = 0; k < 16; k++) mreg[k] = '0;
        tick();
        tick();
        wvalid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bvalid !== 1'b0 || o_regs !== flat_model() || {awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL mid_reset: bv=%b reg3=%h rdy=%b required 0 0 111",
                     bvalid, o_regs[127:96], {awready, wready, arready});
        end
        model_read(8'h0C);
        do_read(8'h0C, rs, rd, lat);
        r = r_q.pop_front();
        checks++;
        if (rs !== r.resp || rd !== r.data) begin
            errors++;
            $display("FAIL mid_read: got %b/%h required %b/%h", rs, rd, r.resp, r.data);
        end
    endtask

    initial begin
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        for (int k = 0; k < 16; k++) mreg[k] = '0;
        test_reset();
        test_simul_write();
        test_split(1'b1);
        test_split(1'b0);
        test_out_of_range();
        test_backpressure();
        test_concurrent();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
